// File: rtl/pu_tag_resp_pkg.sv
// Shared types, address map and helpers for the PU tag-lookup return path.
package pu_tag_resp_pkg;

    localparam int NUM_OF_PU      = 20;
    localparam int PU_WIDTH_NBITS = 32;
    localparam int RCI_NBITS      = 16;
    localparam int PU_ID_NBITS    = 5;
    localparam int MAX_RES        = 8;
    localparam int RES_NUM_NBITS  = 3;
    localparam int ADDR_NBITS     = 8;
    localparam int REGION_NBITS   = ADDR_NBITS - RES_NUM_NBITS;
    localparam int RAM_DEPTH      = NUM_OF_PU * MAX_RES;
    localparam int RAM_AW         = PU_ID_NBITS + RES_NUM_NBITS;

    // Region codes live in the address bits above the result slot index
    localparam logic [REGION_NBITS-1:0] PU_TAG_LOOKUP_REQ    = 5'h01;
    localparam logic [REGION_NBITS-1:0] PU_TAG_LOOKUP_STATUS = 5'h02;
    localparam logic [REGION_NBITS-1:0] PU_TAG_LOOKUP_RESULT = 5'h03;

    typedef struct packed {
        logic                      wr;
        logic [ADDR_NBITS-1:0]     addr;
        logic [PU_WIDTH_NBITS-1:0] wdata;
    } io_type;

    typedef struct packed {
        logic       done;
        logic [3:0] status;
    } tag_status_rd_t;

    function automatic logic [REGION_NBITS-1:0] region_of(input logic [ADDR_NBITS-1:0] addr);
        return addr[ADDR_NBITS-1:RES_NUM_NBITS];
    endfunction

    function automatic logic [RAM_AW-1:0] ram_addr(input logic [PU_ID_NBITS-1:0]   pid,
                                                   input logic [RES_NUM_NBITS-1:0] slot);
        return {pid, slot};
    endfunction

endpackage

// File: rtl/pu_tag_resp_if.sv
// Per-PU io request/acknowledge bus shared with the tag request block.
interface pu_tag_resp_if
    import pu_tag_resp_pkg::*;
    ();

    logic [NUM_OF_PU-1:0]      io_req;
    io_type                    io_cmd      [NUM_OF_PU];
    logic [NUM_OF_PU-1:0]      io_ack;
    logic [PU_WIDTH_NBITS-1:0] io_ack_data [NUM_OF_PU];

    modport master (
        output io_req,
        output io_cmd,
        input  io_ack,
        input  io_ack_data
    );

    modport slave (
        input  io_req,
        input  io_cmd,
        output io_ack,
        output io_ack_data
    );

endinterface

// File: rtl/pu_tag_resp_rr_arb.sv
// Round-robin arbiter: one grant per cycle, priority rotates past the last winner.
module pu_tag_resp_rr_arb #(
    parameter int N  = 20,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_r;
    int            cand_s;

    // Scan from farthest to nearest so the requester closest to ptr_r wins
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand_s  = 0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                cand_s = int'(ptr_r) + k;
                if (cand_s >= N) begin
                    cand_s = cand_s - N;
                end else begin
                    cand_s = cand_s;
                end
                if (req[cand_s]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(cand_s);
                end else begin
                    gnt_vld = gnt_vld;
                end
            end
            gnt = gnt_vld ? (N'(1'b1) << gnt_idx) : '0;
        end else begin
            gnt = '0;
        end
    end

    // Priority pointer moves to the slot after each winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (gnt_vld) begin
            ptr_r <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/pu_tag_resp.sv
// Tag lookup return path: stores per-PU results and status, answers PU status/result reads.
module pu_tag_resp
    import pu_tag_resp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tag_lookup_valid,
    input  logic [RCI_NBITS-1:0]   tag_lookup_result,
    input  logic [2:0]             tag_lookup_result_num,
    input  logic [PU_ID_NBITS-1:0] tag_lookup_result_pid,
    input  logic                   tag_lookup_status_valid,
    input  logic [3:0]             tag_lookup_status,
    input  logic [PU_ID_NBITS-1:0] tag_lookup_status_pid,
    pu_tag_resp_if.slave           io
);

    logic [NUM_OF_PU-1:0]      done_r;
    logic [3:0]                stat_r      [NUM_OF_PU];
    logic [NUM_OF_PU-1:0]      rd_pend_r;
    logic [2:0]                slot_r      [NUM_OF_PU];
    logic                      gnt_vld_r;
    logic [PU_ID_NBITS-1:0]    gnt_pid_r;
    logic [RCI_NBITS-1:0]      ram_q_r;
    logic [RCI_NBITS-1:0]      ram_mem     [RAM_DEPTH];
    logic [NUM_OF_PU-1:0]      io_ack_r;
    logic [PU_WIDTH_NBITS-1:0] ack_data_r  [NUM_OF_PU];

    logic [NUM_OF_PU-1:0]      req_wr_s;
    logic [NUM_OF_PU-1:0]      stat_rd_s;
    logic [NUM_OF_PU-1:0]      res_rd_s;
    logic [NUM_OF_PU-1:0]      st_hit_s;
    logic [NUM_OF_PU-1:0]      res_ack_s;
    tag_status_rd_t            stat_word_s [NUM_OF_PU];
    logic [NUM_OF_PU-1:0]      gnt_s;
    logic                      gnt_vld_s;
    logic [PU_ID_NBITS-1:0]    gnt_idx_s;
    logic                      ram_we_s;
    logic [RAM_AW-1:0]         ram_waddr_s;
    logic [RAM_AW-1:0]         ram_raddr_s;
    logic                      wdata_unused_s;

    // Per-PU command decode and status/result-ack bookkeeping
    always_comb begin
        req_wr_s       = '0;
        stat_rd_s      = '0;
        res_rd_s       = '0;
        st_hit_s       = '0;
        res_ack_s      = '0;
        wdata_unused_s = 1'b0;
        for (int i = 0; i < NUM_OF_PU; i++) begin
            stat_word_s[i] = '{done: done_r[i], status: stat_r[i]};
            res_ack_s[i]   = gnt_vld_r && (gnt_pid_r == PU_ID_NBITS'(i));
            st_hit_s[i]    = tag_lookup_status_valid && (tag_lookup_status_pid == PU_ID_NBITS'(i));
            wdata_unused_s = wdata_unused_s ^ (^io.io_cmd[i].wdata);
            if (io.io_req[i] && io.io_cmd[i].wr) begin
                req_wr_s[i] = (region_of(io.io_cmd[i].addr) == PU_TAG_LOOKUP_REQ);
            end else if (io.io_req[i]) begin
                // A status ack must not collide with a result ack leaving the pipe
                stat_rd_s[i] = (region_of(io.io_cmd[i].addr) == PU_TAG_LOOKUP_STATUS) && !res_ack_s[i];
                res_rd_s[i]  = (region_of(io.io_cmd[i].addr) == PU_TAG_LOOKUP_RESULT) && !rd_pend_r[i];
            end else begin
                req_wr_s[i] = 1'b0;
            end
        end
    end

    // done: new request clears, completion sets, returning done=1 clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= '0;
            for (int i = 0; i < NUM_OF_PU; i++) begin
                stat_r[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_PU; i++) begin
                if (req_wr_s[i]) begin
                    done_r[i] <= 1'b0;
                end else if (st_hit_s[i]) begin
                    done_r[i] <= 1'b1;
                end else if (stat_rd_s[i] && done_r[i]) begin
                    done_r[i] <= 1'b0;
                end else begin
                    done_r[i] <= done_r[i];
                end
                if (st_hit_s[i]) begin
                    stat_r[i] <= tag_lookup_status;
                end else begin
                    stat_r[i] <= stat_r[i];
                end
            end
        end
    end

    // Pending result reads and their requested slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r <= '0;
            for (int i = 0; i < NUM_OF_PU; i++) begin
                slot_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_PU; i++) begin
                if (res_rd_s[i]) begin
                    rd_pend_r[i] <= 1'b1;
                    slot_r[i]    <= io.io_cmd[i].addr[RES_NUM_NBITS-1:0];
                end else if (gnt_s[i]) begin
                    rd_pend_r[i] <= 1'b0;
                end else begin
                    rd_pend_r[i] <= rd_pend_r[i];
                end
            end
        end
    end

    pu_tag_resp_rr_arb #(
        .N  (NUM_OF_PU),
        .IW (PU_ID_NBITS)
    ) u_rr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (1'b1),
        .req     (rd_pend_r),
        .gnt     (gnt_s),
        .gnt_vld (gnt_vld_s),
        .gnt_idx (gnt_idx_s)
    );

    assign ram_we_s    = tag_lookup_valid && (tag_lookup_result_pid < PU_ID_NBITS'(NUM_OF_PU));
    assign ram_waddr_s = ram_addr(tag_lookup_result_pid, tag_lookup_result_num);
    assign ram_raddr_s = ram_addr(gnt_idx_s, slot_r[gnt_idx_s]);

    // Result store: registered read sees the pre-write contents on an address clash
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_mem[ram_waddr_s] <= tag_lookup_result;
        end
        if (gnt_vld_s) begin
            ram_q_r <= ram_mem[ram_raddr_s];
        end
    end

    // Track which PU owns the RAM read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_vld_r <= 1'b0;
            gnt_pid_r <= '0;
        end else begin
            gnt_vld_r <= gnt_vld_s;
            gnt_pid_r <= gnt_idx_s;
        end
    end

    // Registered acknowledge and read data per PU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_ack_r <= '0;
            for (int i = 0; i < NUM_OF_PU; i++) begin
                ack_data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_PU; i++) begin
                io_ack_r[i] <= res_ack_s[i] | stat_rd_s[i];
                if (res_ack_s[i]) begin
                    ack_data_r[i] <= PU_WIDTH_NBITS'(ram_q_r);
                end else if (stat_rd_s[i]) begin
                    ack_data_r[i] <= PU_WIDTH_NBITS'(stat_word_s[i]);
                end else begin
                    ack_data_r[i] <= '0;
                end
            end
        end
    end

    assign io.io_ack      = io_ack_r;
    assign io.io_ack_data = ack_data_r;

endmodule

// File: tb/tb_pu_tag_resp.sv
// Directed bench for pu_tag_resp with hand-computed expected values.
module tb_pu_tag_resp;
    import pu_tag_resp_pkg::*;

    localparam logic [7:0] A_REQ    = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h10;
    localparam logic [7:0] A_RESULT = 8'h18;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   tl_valid;
    logic [RCI_NBITS-1:0]   tl_result;
    logic [2:0]             tl_num;
    logic [PU_ID_NBITS-1:0] tl_pid;
    logic                   ts_valid;
    logic [3:0]             ts_status;
    logic [PU_ID_NBITS-1:0] ts_pid;

    int n_checks = 0;
    int n_fail   = 0;

    pu_tag_resp_if bus ();

    pu_tag_resp dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .tag_lookup_valid        (tl_valid),
        .tag_lookup_result       (tl_result),
        .tag_lookup_result_num   (tl_num),
        .tag_lookup_result_pid   (tl_pid),
        .tag_lookup_status_valid (ts_valid),
        .tag_lookup_status       (ts_status),
        .tag_lookup_status_pid   (ts_pid),
        .io                      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic io_drive(input int pid, input logic wr, input logic [7:0] addr);
        bus.io_req[pid] = 1'b1;
        bus.io_cmd[pid] = '{wr: wr, addr: addr, wdata: 32'h0};
    endtask

    task automatic io_idle();
        bus.io_req = '0;
    endtask

    task automatic push_result(input int pid, input int slot, input logic [15:0] data);
        tl_valid = 1'b1; tl_pid = 5'(pid); tl_num = 3'(slot); tl_result = data;
        step();
        tl_valid = 1'b0;
    endtask

    task automatic push_status(input int pid, input logic [3:0] st);
        ts_valid = 1'b1; ts_pid = 5'(pid); ts_status = st;
        step();
        ts_valid = 1'b0;
    endtask

    task automatic status_read(input int pid, input logic [31:0] exp, input string tag);
        io_drive(pid, 1'b0, A_STATUS);
        step();
        io_idle();
        chk({tag, "_ack"}, 32'(bus.io_ack[pid]), 32'd1);
        chk({tag, "_data"}, bus.io_ack_data[pid], exp);
    endtask

    task automatic result_read(input int pid, input int slot, input logic [31:0] exp, input string tag);
        int lat;
        io_drive(pid, 1'b0, A_RESULT | 8'(slot));
        step();
        io_idle();
        lat = 1;
        while (!bus.io_ack[pid] && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, bus.io_ack_data[pid], exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ack", 32'(bus.io_ack), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [19:0] ev;
        logic        seen;
        io_idle();
        for (int i = 0; i < NUM_OF_PU; i++) begin
            bus.io_cmd[i] = '{wr: 1'b0, addr: 8'h00, wdata: 32'h0};
        end
        tl_valid = 1'b0; tl_result = '0; tl_num = '0; tl_pid = '0;
        ts_valid = 1'b0; ts_status = '0; ts_pid = '0;
        do_reset();
        chk("rst_data0", bus.io_ack_data[0], 32'h0);
        chk("rst_data19", bus.io_ack_data[19], 32'h0);

        // PU3 basic flow
        io_drive(3, 1'b1, A_REQ); step(); io_idle();
        push_result(3, 0, 16'h0011);
        push_result(3, 1, 16'h0022);
        push_result(3, 2, 16'h0033);
        push_status(3, 4'h1);
        status_read(3, 32'h11, "pu3_status");
        result_read(3, 1, 32'h22, "pu3_slot1");
        result_read(3, 2, 32'h33, "pu3_slot2");

        // Write to the slot being read in the same cycle returns old data
        io_drive(3, 1'b0, A_RESULT | 8'h01); step(); io_idle();
        tl_valid = 1'b1; tl_pid = 5'd3; tl_num = 3'd1; tl_result = 16'h0099;
        step();
        tl_valid = 1'b0;
        step();
        chk("rw_clash_ack", 32'(bus.io_ack[3]), 32'd1);
        chk("rw_clash_data", bus.io_ack_data[3], 32'h22);
        result_read(3, 1, 32'h99, "rw_after");

        // Poll before and after completion, read-to-clear
        status_read(5, 32'h00, "pu5_early");
        push_status(5, 4'hA);
        status_read(5, 32'h1A, "pu5_done");
        status_read(5, 32'h0A, "pu5_cleared");

        // Completion and status read same cycle
        ts_valid = 1'b1; ts_pid = 5'd9; ts_status = 4'h6;
        io_drive(9, 1'b0, A_STATUS);
        step();
        ts_valid = 1'b0; io_idle();
        chk("pu9_same_data", bus.io_ack_data[9], 32'h00);
        status_read(9, 32'h16, "pu9_next");

        // New request wins over completion
        ts_valid = 1'b1; ts_pid = 5'd7; ts_status = 4'h3;
        io_drive(7, 1'b1, A_REQ);
        step();
        ts_valid = 1'b0; io_idle();
        io_drive(7, 1'b0, A_STATUS); step(); io_idle();
        chk("pu7_req_wins", 32'(bus.io_ack_data[7][4]), 32'd0);

        // Unmapped address never acked
        io_drive(7, 1'b0, 8'h40); step(); io_idle();
        seen = bus.io_ack[7];
        for (int c = 0; c < 4; c++) begin
            step();
            seen = seen | bus.io_ack[7];
        end
        chk("unmapped_noack", 32'(seen), 32'd0);

        // Result ack and status ack to different PUs in the same cycle
        push_result(10, 4, 16'h0044);
        io_drive(10, 1'b0, A_RESULT | 8'h04); step(); io_idle();
        step();
        io_drive(11, 1'b0, A_STATUS); step(); io_idle();
        chk("co_ack10", 32'(bus.io_ack[10]), 32'd1);
        chk("co_data10", bus.io_ack_data[10], 32'h44);
        chk("co_ack11", 32'(bus.io_ack[11]), 32'd1);
        chk("co_data11", bus.io_ack_data[11], 32'h00);

        // All 20 PUs read at once: one ack per cycle in round-robin order
        do_reset();
        for (int p = 0; p < NUM_OF_PU; p++) begin
            push_result(p, 0, 16'h0100 + 16'(p));
        end
        for (int p = 0; p < NUM_OF_PU; p++) begin
            io_drive(p, 1'b0, A_RESULT);
        end
        step();
        io_idle();
        for (int c = 1; c <= 24; c++) begin
            ev = (c >= 3 && c <= 22) ? (20'd1 << (c - 3)) : 20'd0;
            chk($sformatf("rr_ack_c%0d", c), 32'(bus.io_ack), 32'(ev));
            if (c >= 3 && c <= 22) begin
                chk($sformatf("rr_data_p%0d", c - 3), bus.io_ack_data[c - 3], 32'h100 + 32'(c - 3));
            end
            step();
        end

        // Reset with reads outstanding discards them
        for (int p = 0; p < 5; p++) begin
            io_drive(p, 1'b0, A_RESULT);
        end
        step();
        io_idle();
        do_reset();
        seen = |bus.io_ack;
        for (int c = 0; c < 8; c++) begin
            step();
            seen = seen | (|bus.io_ack);
        end
        chk("rst_pend_noack", 32'(seen), 32'd0);
        for (int p = 0; p < 5; p++) begin
            io_drive(p, 1'b0, A_STATUS); step(); io_idle();
            chk($sformatf("rst_done_p%0d", p), 32'(bus.io_ack_data[p][4]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
